// File: rtl/fir_mac_sequencer.sv
// One multiply-accumulate pass per accepted sample over a TAPS-deep history,
// with coefficients from a synchronous ROM, then rescale and saturate to N bits.
module fir_mac_sequencer #(
    parameter int N     = 24,
    parameter int TAPS  = 5,
    parameter int AW    = 3,
    parameter int FRAC  = 10,
    parameter int GUARD = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          sample_valid,
    input  logic [N-1:0]  sample_in,
    output logic          sample_ready,
    output logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_data,
    output logic [N-1:0]  y_out,
    output logic          y_valid,
    output logic          sat_flag
);

    localparam int ACC_W = 2 * N + GUARD;
    localparam int CW    = $clog2(TAPS + 1);

    localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

    state_t                    state_reg, state_next;
    logic signed [N-1:0]       history_reg [TAPS];
    logic signed [ACC_W-1:0]   acc_reg;
    logic [CW-1:0]             tap_reg;
    logic [TAPS-1:0]           tap_hit;
    logic signed [N-1:0]       mac_sample;
    logic signed [2*N-1:0]     product;
    logic signed [ACC_W-1:0]   product_ext;
    logic signed [ACC_W-1:0]   scaled;
    logic [N-1:0]              sat_y;
    logic                      sat_hit;
    logic                      accept;

    assign accept = sample_valid && sample_ready;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; tap_reg==TAPS marks the last accumulation edge
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (tap_reg == CW'(TAPS)) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        sample_ready = (state_reg == IDLE);
    end

    // tap_reg==k+1 selects history[k]; tap_reg==0 is the ROM latency slot
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap_sel
            assign tap_hit[gi] = (tap_reg == CW'(gi + 1));
        end
    endgenerate

    always_comb begin
        mac_sample = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (tap_hit[i]) mac_sample = history_reg[i];
        end
    end

    assign product     = mac_sample * $signed(coef_data);
    assign product_ext = {{GUARD{product[2*N-1]}}, product};
    assign scaled      = acc_reg >>> FRAC;

    always_comb begin
        sat_y   = scaled[N-1:0];
        sat_hit = 1'b0;
        if (scaled > S_MAX) begin
            sat_y   = S_MAX[N-1:0];
            sat_hit = 1'b1;
        end else if (scaled < S_MIN) begin
            sat_y   = S_MIN[N-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < TAPS; i++) history_reg[i] <= '0;
        end else if (accept) begin
            history_reg[0] <= sample_in;
            for (int i = 1; i < TAPS; i++) history_reg[i] <= history_reg[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc_reg   <= '0;
            tap_reg   <= '0;
            coef_addr <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_reg   <= '0;
                        tap_reg   <= '0;
                        coef_addr <= '0;
                    end
                end
                MAC: begin
                    tap_reg <= tap_reg + CW'(1);
                    if (coef_addr != AW'(TAPS - 1)) coef_addr <= coef_addr + AW'(1);
                    if (tap_reg != '0) acc_reg <= acc_reg + product_ext;
                end
                SAT: begin
                    y_out    <= sat_y;
                    sat_flag <= sat_hit;
                    y_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// pops and checks them whenever y_valid is seen.
module tb_fir_mac_sequencer;

    localparam int N    = 24;
    localparam int TAPS = 5;
    localparam int AW   = 3;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          sample_valid = 1'b0;
    logic [N-1:0]  sample_in = '0;
    logic          sample_ready;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_data = '0;
    logic [N-1:0]  y_out;
    logic          y_valid;
    logic          sat_flag;

    fir_mac_sequencer #(.N(N), .TAPS(TAPS), .AW(AW), .FRAC(10), .GUARD(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .sample_valid(sample_valid), .sample_in(sample_in), .sample_ready(sample_ready),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .y_out(y_out), .y_valid(y_valid), .sat_flag(sat_flag)
    );

    always #5 CLK = ~CLK;

    logic [N-1:0] rom [TAPS];
    always @(posedge CLK) coef_data <= (int'(coef_addr) < TAPS) ? rom[coef_addr] : '0;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] y;
        logic         sat;
        int           acc_cyc;
    } exp_t;
    exp_t q[$];
    int last_accept = 0;

    function automatic logic [N-1:0] v(input int x);
        return x[N-1:0];
    endfunction

    task automatic set_rom(input int c0, input int c1, input int c2, input int c3, input int c4);
        rom[0] = v(c0); rom[1] = v(c1); rom[2] = v(c2); rom[3] = v(c3); rom[4] = v(c4);
    endtask

    // Monitor: address range every cycle, scoreboard pop on every result
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET) begin
            checks++;
            if (int'(coef_addr) > TAPS - 1) begin
                failures++;
                $display("FAIL coef_addr_range got=%0d max=%0d", coef_addr, TAPS - 1);
            end
            if (y_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_y_valid y=%0d cyc=%0d", $signed(y_out), cyc);
                end else begin
                    e = q.pop_front();
                    $display("txn y=%0d sat=%0d exp_y=%0d exp_sat=%0d lat=%0d",
                             $signed(y_out), sat_flag, $signed(e.y), e.sat, cyc - e.acc_cyc);
                    if (y_out !== e.y || sat_flag !== e.sat) begin
                        failures++;
                        $display("FAIL result y=%0d sat=%0d expected y=%0d sat=%0d",
                                 $signed(y_out), sat_flag, $signed(e.y), e.sat);
                    end
                    checks++;
                    if (cyc - e.acc_cyc != TAPS + 2) begin
                        failures++;
                        $display("FAIL latency got=%0d expected=%0d", cyc - e.acc_cyc, TAPS + 2);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge
    task automatic send(input int s, input int ey, input logic es, input bit expect_out, input bit keep);
        int  waited = 0;
        bit  ok = 0;
        sample_in    = v(s);
        sample_valid = 1'b1;
        while (!ok && waited < 100) begin
            if (sample_ready) begin
                @(posedge CLK);
                #1;
                ok = 1;
            end else begin
                @(negedge CLK);
                waited++;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout sample=%0d waited=%0d", s, waited);
        end else begin
            last_accept = cyc;
            if (expect_out) q.push_back('{v(ey), es, cyc});
        end
        if (!keep) sample_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic check1(input string nm, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, $signed(got), $signed(want));
        end
    endtask

    int a0, a1, a2;

    initial begin
        set_rom(1024, 1024, 1024, 1024, 1024);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        check1("reset_y_out", y_out, '0);
        check1("reset_y_valid", v(int'(y_valid)), '0);
        check1("reset_sat_flag", v(int'(sat_flag)), '0);
        check1("reset_ready", v(int'(sample_ready)), v(1));
        check1("reset_coef_addr", v(int'(coef_addr)), '0);

        // Handshake + impulse, unity coefficients
        send(1024, 1024, 1'b0, 1, 0);
        for (int i = 0; i < TAPS + 2; i++) begin
            check1("ready_low_busy", v(int'(sample_ready)), '0);
            @(negedge CLK);
        end
        check1("ready_high_after", v(int'(sample_ready)), v(1));
        send(0, 1024, 1'b0, 1, 0);
        send(0, 1024, 1'b0, 1, 0);
        send(0, 1024, 1'b0, 1, 0);
        send(0, 1024, 1'b0, 1, 0);
        send(0, 0, 1'b0, 1, 0);
        drain();

        // Distinct coefficients expose address/tap ordering
        set_rom(1024, 512, 256, 128, 64);
        send(1024, 1024, 1'b0, 1, 0);
        send(0, 512, 1'b0, 1, 0);
        send(0, 256, 1'b0, 1, 0);
        send(0, 128, 1'b0, 1, 0);
        send(0, 64, 1'b0, 1, 0);
        drain();

        // Sign handling and floor rounding of the arithmetic shift
        do_reset();
        set_rom(-512, -512, -512, -512, -512);
        send(2048, -1024, 1'b0, 1, 0);
        send(2048, -2048, 1'b0, 1, 0);
        send(0, -2048, 1'b0, 1, 0);
        send(-2048, -1024, 1'b0, 1, 0);
        send(3, -1026, 1'b0, 1, 0);
        drain();

        // Positive saturation
        do_reset();
        set_rom(1024, 1024, 1024, 1024, 1024);
        send(8388607, 8388607, 1'b0, 1, 0);
        for (int i = 0; i < 4; i++) send(8388607, 8388607, 1'b1, 1, 0);
        drain();

        // Negative saturation
        do_reset();
        send(-8388608, -8388608, 1'b0, 1, 0);
        for (int i = 0; i < 4; i++) send(-8388608, -8388608, 1'b1, 1, 0);
        drain();

        // Backpressure: valid held high across three samples
        do_reset();
        send(100, 100, 1'b0, 1, 1);
        a0 = last_accept;
        send(200, 300, 1'b0, 1, 1);
        a1 = last_accept;
        send(300, 600, 1'b0, 1, 0);
        a2 = last_accept;
        check1("accept_spacing_1", v(a1 - a0), v(TAPS + 3));
        check1("accept_spacing_2", v(a2 - a1), v(TAPS + 3));
        drain();

        // Reset two cycles into a pass
        send(1024, 0, 1'b0, 0, 0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check1("midreset_y_out", y_out, '0);
        check1("midreset_y_valid", v(int'(y_valid)), '0);
        check1("midreset_sat", v(int'(sat_flag)), '0);
        check1("midreset_coef_addr", v(int'(coef_addr)), '0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check1("midreset_ready", v(int'(sample_ready)), v(1));
        repeat (10) @(negedge CLK);
        check1("midreset_y_out_hold", y_out, '0);
        send(1024, 1024, 1'b0, 1, 0);
        send(0, 1024, 1'b0, 1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
